// File: rtl/sdp_rd_arb.sv
// sdp_rd_arb
//   Shares the single read port of an sdp memory between two requesters.
//   The address side uses round-robin arbitration. An in-order tag FIFO
//   remembers which requester issued each outstanding read, so that every
//   response is steered back to its owner. The block adds no latency: it is
//   combinational steering plus tag bookkeeping.
//
// Ports
//   clk, rst                    clock, synchronous active-low reset
//   r0_addr_* / r1_addr_*       requester read-address channels (valid/ready/data)
//   r0_data_* / r1_data_*       requester read-data channels (valid/ready/data)
//   m_addr_*                    to the sdp read-port address channel
//   m_data_*                    from the sdp read-port data channel
//   busy                        at least one read outstanding
module sdp_rd_arb #(
    parameter int W_ADDR    = 16,
    parameter int W_DATA    = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_addr_valid,
    output logic              r0_addr_ready,
    input  logic [W_ADDR-1:0] r0_addr_data,
    output logic              r0_data_valid,
    input  logic              r0_data_ready,
    output logic [W_DATA-1:0] r0_data_data,

    input  logic              r1_addr_valid,
    output logic              r1_addr_ready,
    input  logic [W_ADDR-1:0] r1_addr_data,
    output logic              r1_data_valid,
    input  logic              r1_data_ready,
    output logic [W_DATA-1:0] r1_data_data,

    output logic              m_addr_valid,
    input  logic              m_addr_ready,
    output logic [W_ADDR-1:0] m_addr_data,
    input  logic              m_data_valid,
    output logic              m_data_ready,
    input  logic [W_DATA-1:0] m_data_data,

    output logic              busy
);

    localparam int PW = $clog2(TAG_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(TAG_DEPTH);

    // Tag FIFO: one bit per outstanding read holding the requester id.
    logic [TAG_DEPTH-1:0] tag_q;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW:0]          count;

    logic prio;       // requester that wins when both are valid
    logic locked;     // m_addr_valid was shown without a handshake
    logic locked_id;  // grant that must be held while locked

    logic tag_full;
    logic has_head;
    logic head;
    logic grant;
    logic addr_hs;
    logic data_hs;

    assign tag_full = (count == FULL_CNT);
    assign has_head = (count != '0);
    assign head     = tag_q[rd_ptr];

    // Grant selection. While locked the previous grant is held, so that a
    // late-arriving higher-priority requester cannot change the address
    // presented downstream before it has been accepted.
    always_comb begin
        grant = 1'b0;
        if (locked)
            grant = locked_id;
        else if (r0_addr_valid && r1_addr_valid)
            grant = prio;
        else
            grant = r1_addr_valid;
    end

    // Address side is gated by rst so nothing is offered while in reset.
    assign m_addr_valid  = rst & (r0_addr_valid | r1_addr_valid) & ~tag_full;
    assign m_addr_data   = grant ? r1_addr_data : r0_addr_data;
    assign r0_addr_ready = rst & ~grant & m_addr_ready & ~tag_full;
    assign r1_addr_ready = rst &  grant & m_addr_ready & ~tag_full;
    assign addr_hs       = m_addr_valid & m_addr_ready;

    // Response side: only the head-tag owner sees the response. Data is
    // broadcast and qualified by valid.
    assign r0_data_valid = m_data_valid & has_head & ~head;
    assign r1_data_valid = m_data_valid & has_head &  head;
    assign r0_data_data  = m_data_data;
    assign r1_data_data  = m_data_data;
    // A response with no outstanding tag is never accepted.
    assign m_data_ready  = has_head & (head ? r1_data_ready : r0_data_ready);
    assign data_hs       = m_data_valid & m_data_ready;

    assign busy = has_head;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            prio      <= 1'b0;
            locked    <= 1'b0;
            locked_id <= 1'b0;
        end else begin
            if (addr_hs) begin
                tag_q[wr_ptr] <= grant;
                wr_ptr        <= wr_ptr + 1'b1;
                prio          <= ~grant;
            end
            if (data_hs)
                rd_ptr <= rd_ptr + 1'b1;

            // Push and pop together leave count unchanged. Full blocks the
            // push even when a pop happens in the same cycle.
            case ({addr_hs, data_hs})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            locked    <= m_addr_valid & ~m_addr_ready;
            locked_id <= grant;
        end
    end

endmodule

// File: tb/tb_sdp_rd_arb.sv
// Directed bench for sdp_rd_arb. The requesters are queue-driven; the sdp read
// port is modelled as a response pipe with ram[a] = a + 0x100.
module tb_sdp_rd_arb;

    localparam int W_ADDR    = 16;
    localparam int W_DATA    = 16;
    localparam int TAG_DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b0;
    logic              r0_addr_valid = 1'b0, r0_addr_ready;
    logic [W_ADDR-1:0] r0_addr_data = '0;
    logic              r0_data_valid, r0_data_ready = 1'b1;
    logic [W_DATA-1:0] r0_data_data;
    logic              r1_addr_valid = 1'b0, r1_addr_ready;
    logic [W_ADDR-1:0] r1_addr_data = '0;
    logic              r1_data_valid, r1_data_ready = 1'b1;
    logic [W_DATA-1:0] r1_data_data;
    logic              m_addr_valid, m_addr_ready = 1'b1;
    logic [W_ADDR-1:0] m_addr_data;
    logic              m_data_valid = 1'b0, m_data_ready;
    logic [W_DATA-1:0] m_data_data = '0;
    logic              busy;

    sdp_rd_arb #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .r0_addr_valid(r0_addr_valid), .r0_addr_ready(r0_addr_ready), .r0_addr_data(r0_addr_data),
        .r0_data_valid(r0_data_valid), .r0_data_ready(r0_data_ready), .r0_data_data(r0_data_data),
        .r1_addr_valid(r1_addr_valid), .r1_addr_ready(r1_addr_ready), .r1_addr_data(r1_addr_data),
        .r1_data_valid(r1_data_valid), .r1_data_ready(r1_data_ready), .r1_data_data(r1_data_data),
        .m_addr_valid(m_addr_valid), .m_addr_ready(m_addr_ready), .m_addr_data(m_addr_data),
        .m_data_valid(m_data_valid), .m_data_ready(m_data_ready), .m_data_data(m_data_data),
        .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] q0[$], q1[$], mq[$];      // pending addresses, memory responses
    logic [15:0] rcv0[$], rcv1[$], alog[$]; // observed deliveries / m_addr log
    logic        hs0 = 0, hs1 = 0, hsm = 0, hsd = 0, rst_s = 0;
    logic [15:0] a_addr = '0;

    // Monitor: sample handshakes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        hs0    = r0_addr_valid & r0_addr_ready;
        hs1    = r1_addr_valid & r1_addr_ready;
        hsm    = m_addr_valid & m_addr_ready;
        hsd    = m_data_valid & m_data_ready;
        a_addr = m_addr_data;
        rst_s  = rst;
        if (hsm === 1'b1) alog.push_back(m_addr_data);
        if ((r0_data_valid & r0_data_ready) === 1'b1) rcv0.push_back(r0_data_data);
        if ((r1_data_valid & r1_data_ready) === 1'b1) rcv1.push_back(r1_data_data);
        if (rst && m_data_valid && busy !== 1'b1) begin
            total++; bad++;
            $display("FAIL illegal_resp: m_data_valid=1 with busy=%b, required busy=1", busy);
        end
    end

    // Requester and memory models update just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst_s) mq.delete();
        else begin
            if (hsd === 1'b1 && mq.size() != 0) void'(mq.pop_front());
            if (hsm === 1'b1) mq.push_back(a_addr + 16'h0100);
        end
        if (hs0 === 1'b1 && q0.size() != 0) void'(q0.pop_front());
        if (hs1 === 1'b1 && q1.size() != 0) void'(q1.pop_front());
        r0_addr_valid = (q0.size() != 0);
        r0_addr_data  = (q0.size() != 0) ? q0[0] : '0;
        r1_addr_valid = (q1.size() != 0);
        r1_addr_data  = (q1.size() != 0) ? q1[0] : '0;
        m_data_valid  = (mq.size() != 0);
        m_data_data   = (mq.size() != 0) ? mq[0] : '0;
    end

    task automatic tick;
        @(posedge clk);
        #3;
    endtask

    task automatic drain;
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || mq.size() != 0 || busy !== 1'b0) && n < 200) begin
            tick;
            n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL drain_timeout: busy=%b q0=%0d q1=%0d mq=%0d, required idle", busy, q0.size(), q1.size(), mq.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        q0.push_back(16'h0030);
        q1.push_back(16'h0040);
        for (int i = 0; i < 3; i++) begin
            tick;
            total++; if (m_addr_valid !== 1'b0) begin bad++; $display("FAIL reset_m_addr_valid cyc=%0d got=%b want=0", i, m_addr_valid); end
            total++; if ({r0_data_valid, r1_data_valid} !== 2'b00) begin bad++; $display("FAIL reset_data_valid cyc=%0d got=%b want=00", i, {r0_data_valid, r1_data_valid}); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy cyc=%0d got=%b want=0", i, busy); end
        end
        rst = 1'b1;
        alog.delete(); rcv0.delete(); rcv1.delete();
        #1;
        total++; if (m_addr_valid !== 1'b1 || m_addr_data !== 16'h0030) begin bad++; $display("FAIL reset_first_grant got v=%b a=%h want v=1 a=0030", m_addr_valid, m_addr_data); end
        total++; if ({r0_addr_ready, r1_addr_ready} !== 2'b10) begin bad++; $display("FAIL reset_first_ready got=%b want=10", {r0_addr_ready, r1_addr_ready}); end
        drain;
        total++; if (rcv0.size() != 1 || rcv0[0] !== 16'h0130) begin bad++; $display("FAIL reset_r0_data got n=%0d want 0130", rcv0.size()); end
        total++; if (rcv1.size() != 1 || rcv1[0] !== 16'h0140) begin bad++; $display("FAIL reset_r1_data got n=%0d want 0140", rcv1.size()); end
    endtask

    task automatic test_alternate;
        logic [15:0] exp_a[6];
        exp_a = '{16'h0010, 16'h0020, 16'h0011, 16'h0021, 16'h0012, 16'h0022};
        alog.delete(); rcv0.delete(); rcv1.delete();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(16'(16'h0010 + i));
            q1.push_back(16'(16'h0020 + i));
        end
        drain;
        total++; if (alog.size() != 6) begin bad++; $display("FAIL alt_addr_count got=%0d want=6", alog.size()); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (i >= alog.size() || alog[i] !== exp_a[i]) begin bad++; $display("FAIL alt_addr[%0d] got=%h want=%h", i, (i < alog.size()) ? alog[i] : 16'hxxxx, exp_a[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= rcv0.size() || rcv0[i] !== 16'(16'h0110 + i)) begin bad++; $display("FAIL alt_r0_data[%0d] n=%0d want=%h", i, rcv0.size(), 16'(16'h0110 + i)); end
            total++;
            if (i >= rcv1.size() || rcv1[i] !== 16'(16'h0120 + i)) begin bad++; $display("FAIL alt_r1_data[%0d] n=%0d want=%h", i, rcv1.size(), 16'(16'h0120 + i)); end
        end
    endtask

    task automatic test_full;
        alog.delete(); rcv0.delete();
        r0_data_ready = 1'b0;
        for (int i = 0; i < 6; i++) q0.push_back(16'(16'h0040 + i));
        repeat (6) tick;
        total++; if (alog.size() != 4) begin bad++; $display("FAIL full_issue_count got=%0d want=4", alog.size()); end
        total++; if (m_addr_valid !== 1'b0) begin bad++; $display("FAIL full_m_addr_valid got=%b want=0", m_addr_valid); end
        total++; if (busy !== 1'b1 || r0_data_valid !== 1'b1) begin bad++; $display("FAIL full_stall got busy=%b r0dv=%b want 1 1", busy, r0_data_valid); end
        r0_data_ready = 1'b1;
        #1;
        total++; if (m_data_ready !== 1'b1 || m_addr_valid !== 1'b0) begin bad++; $display("FAIL full_pop_no_bypass got mdr=%b mav=%b want 1 0", m_data_ready, m_addr_valid); end
        tick;
        total++; if (m_addr_valid !== 1'b1 || alog.size() != 4) begin bad++; $display("FAIL full_regrant got mav=%b n=%0d want 1 4", m_addr_valid, alog.size()); end
        tick;
        total++; if (alog.size() != 5) begin bad++; $display("FAIL full_regrant_hs got=%0d want=5", alog.size()); end
        drain;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (i >= rcv0.size() || rcv0[i] !== 16'(16'h0140 + i)) begin bad++; $display("FAIL full_r0_data[%0d] n=%0d want=%h", i, rcv0.size(), 16'(16'h0140 + i)); end
        end
    endtask

    task automatic test_hol;
        rcv0.delete(); rcv1.delete();
        r0_data_ready = 1'b0;
        q0.push_back(16'h0005);
        tick;
        q1.push_back(16'h0006);
        for (int i = 0; i < 5; i++) begin
            tick;
            total++; if (r1_data_valid !== 1'b0) begin bad++; $display("FAIL hol_r1_valid cyc=%0d got=%b want=0", i, r1_data_valid); end
        end
        total++; if (r0_data_valid !== 1'b1 || r0_data_data !== 16'h0105) begin bad++; $display("FAIL hol_r0_head got v=%b d=%h want 1 0105", r0_data_valid, r0_data_data); end
        r0_data_ready = 1'b1;
        tick;
        total++; if (r1_data_valid !== 1'b1 || r1_data_data !== 16'h0106) begin bad++; $display("FAIL hol_r1_next got v=%b d=%h want 1 0106", r1_data_valid, r1_data_data); end
        drain;
        total++; if (rcv0.size() != 1 || rcv0[0] !== 16'h0105) begin bad++; $display("FAIL hol_r0_data n=%0d want 0105", rcv0.size()); end
        total++; if (rcv1.size() != 1 || rcv1[0] !== 16'h0106) begin bad++; $display("FAIL hol_r1_data n=%0d want 0106", rcv1.size()); end
    endtask

    task automatic test_lock;
        // One r0 read first so the priority pointer names r1.
        q0.push_back(16'h0001);
        drain;
        m_addr_ready = 1'b0;
        q0.push_back(16'h0050);
        tick;
        total++; if (m_addr_valid !== 1'b1 || m_addr_data !== 16'h0050) begin bad++; $display("FAIL lock_first got v=%b a=%h want 1 0050", m_addr_valid, m_addr_data); end
        q1.push_back(16'h0060);
        for (int i = 0; i < 3; i++) begin
            tick;
            total++; if (m_addr_data !== 16'h0050) begin bad++; $display("FAIL lock_hold cyc=%0d got=%h want=0050", i, m_addr_data); end
        end
        alog.delete();
        m_addr_ready = 1'b1;
        #1;
        total++; if ({r0_addr_ready, r1_addr_ready} !== 2'b10) begin bad++; $display("FAIL lock_ready got=%b want=10", {r0_addr_ready, r1_addr_ready}); end
        drain;
        total++; if (alog.size() != 2 || alog[0] !== 16'h0050 || alog[1] !== 16'h0060) begin bad++; $display("FAIL lock_order n=%0d want 0050,0060", alog.size()); end
    endtask

    task automatic test_reset_mid;
        r0_data_ready = 1'b0;
        for (int i = 0; i < 3; i++) q0.push_back(16'(16'h0070 + i));
        repeat (5) tick;
        total++; if (busy !== 1'b1 || r0_data_valid !== 1'b1) begin bad++; $display("FAIL mid_outstanding got busy=%b r0dv=%b want 1 1", busy, r0_data_valid); end
        rst = 1'b0;
        tick;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
        total++; if ({r0_data_valid, r1_data_valid} !== 2'b00) begin bad++; $display("FAIL mid_data_valid got=%b want=00", {r0_data_valid, r1_data_valid}); end
        rst = 1'b1;
        r0_data_ready = 1'b1;
        rcv0.delete(); rcv1.delete();
        q1.push_back(16'h0007);
        drain;
        total++; if (rcv1.size() != 1 || rcv1[0] !== 16'h0107) begin bad++; $display("FAIL mid_fresh_r1 n=%0d want 0107", rcv1.size()); end
        total++; if (rcv0.size() != 0) begin bad++; $display("FAIL mid_stale_r0 got n=%0d want 0", rcv0.size()); end
    endtask

    initial begin
        test_reset;
        test_alternate;
        test_full;
        test_hol;
        test_lock;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
